// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with programmable wait and byte-lane stores
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [3:0] cnt, cnt_next;
  logic [31:0] a_addr, a_wdata, r_addr, r_wdata, wd, mask;
  logic [1:0] a_size, r_size;
  logic a_we, r_we, accept, enter, err, commit;
  logic [AW-1:0] w;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = state == IDLE && rst;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  always_comb begin
    next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (accept) begin
        next = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_next = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end
      WAIT: begin
        next = cnt == 4'd0 ? RESP : WAIT;
        cnt_next = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end
      default: next = IDLE;
    endcase
  end
  // With zero wait the request enters RESP on its accept edge, so check the live inputs
  assign r_addr  = state == IDLE ? req_addr  : a_addr;
  assign r_wdata = state == IDLE ? req_wdata : a_wdata;
  assign r_size  = state == IDLE ? req_size  : a_size;
  assign r_we    = state == IDLE ? req_we    : a_we;
  assign enter = next == RESP && state != RESP;
  assign err = r_size == 2'b11 || (r_size == 2'b00 && r_addr[1:0] != 2'b00) ||
               (r_size == 2'b01 && r_addr[0]) || {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign commit = enter && r_we && !err;
  assign w = r_addr[AW+1:2];
  assign wd = r_size == 2'b00 ? r_wdata : r_size == 2'b01 ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
  assign mask = r_size == 2'b00 ? 32'hFFFF_FFFF :
                r_size == 2'b01 ? 32'h0000_FFFF << {r_addr[1], 4'b0} :
                32'h0000_00FF << {r_addr[1:0], 3'b0};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_addr    <= '0;
      a_wdata   <= '0;
      a_size    <= '0;
      a_we      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next;
      cnt   <= cnt_next;
      if (accept) begin
        a_addr  <= req_addr;
        a_wdata <= req_wdata;
        a_size  <= req_size;
        a_we    <= req_we;
      end
      rsp_rdata <= enter && !err && !r_we ? mem[w] : '0;
      rsp_err   <= enter && err;
    end
  end
  always_ff @(posedge clk)
    if (commit) mem[w] <= (mem[w] & ~mask) | (wd & mask);
endmodule
